// File: rtl/mdio_ctrl.sv
// mdio_ctrl: arbitrates one clause22/45 mdio master between NUM_REQ clients
// and a built-in BMSR link poller. Clients hold a command until they get a
// one-cycle response; the poller owns the last round-robin slot.
module mdio_ctrl #(
   parameter int NUM_REQ     = 2,
   parameter int POLL_PERIOD = 1000000
) (
   input  logic                    clk,
   input  logic                    arst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0]      req_mode,
   input  logic [12*NUM_REQ-1:0]   req_conf,
   input  logic [16*NUM_REQ-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      resp_valid,
   output logic [15:0]             resp_rdata,
   output logic                    busy,
   input  logic                    poll_en,
   input  logic [4:0]              poll_phy,
   output logic                    link_up,
   output logic                    link_change,
   output logic                    mdio_start,
   output logic                    mdio_mode,
   output logic [11:0]             mdio_conf,
   output logic [15:0]             mdio_wdata,
   input  logic                    mdio_done,
   input  logic [15:0]             mdio_rdata
);

   localparam int PW = (NUM_REQ + 1 > 1) ? $clog2(NUM_REQ + 1) : 1;
   localparam int CW = $clog2(POLL_PERIOD);
   localparam logic [PW-1:0] POLL_SLOT = PW'(NUM_REQ);
   localparam logic [CW-1:0] CNT_LAST  = CW'(POLL_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t               state;
   state_t               next_state;
   logic [PW-1:0]        rr_ptr;
   logic [PW-1:0]        owner;
   logic [CW-1:0]        poll_cnt;
   logic                 poll_pending;
   logic                 done_sync1;
   logic                 done_sync2;
   logic                 done_prev;
   logic                 done_rise;
   logic [NUM_REQ:0]     cand;
   logic                 grant_found;
   logic [PW-1:0]        grant_idx;
   logic                 sel_mode;
   logic [11:0]          sel_conf;
   logic [15:0]          sel_wdata;
   logic [NUM_REQ-1:0]   resp_onehot;
   logic                 owner_is_poll;

   assign done_rise     = done_sync2 & ~done_prev;
   assign cand          = {poll_pending, req_valid};
   assign owner_is_poll = (owner == POLL_SLOT);

   // Bring the mdc-domain done level into clk and keep its previous value for edge detect.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         done_sync1 <= 1'b0;
         done_sync2 <= 1'b0;
         done_prev  <= 1'b0;
      end else begin
         done_sync1 <= mdio_done;
         done_sync2 <= done_sync1;
         done_prev  <= done_sync2;
      end
   end

   // Round-robin search: first candidate at or after rr_ptr, wrapping over NUM_REQ+1 slots.
   always_comb begin
      int pos;
      pos         = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k <= NUM_REQ; k++) begin
         pos = int'(rr_ptr) + k;
         if (pos > NUM_REQ) begin
            pos = pos - (NUM_REQ + 1);
         end else begin
            pos = pos;
         end
         for (int j = 0; j <= NUM_REQ; j++) begin
            if (!grant_found && (pos == j) && cand[j]) begin
               grant_found = 1'b1;
               grant_idx   = PW'(j);
            end else begin
               grant_found = grant_found;
            end
         end
      end
   end

   // Command fields of the granted slot; the poll slot reads BMSR (reg 1) in clause22.
   always_comb begin
      sel_mode  = 1'b0;
      sel_conf  = {2'b10, poll_phy, 5'd1};
      sel_wdata = 16'h0000;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == PW'(i)) begin
            sel_mode  = req_mode[i];
            sel_conf  = req_conf[12*i +: 12];
            sel_wdata = req_wdata[16*i +: 16];
         end else begin
            sel_mode  = sel_mode;
         end
      end
   end

   // One-hot response vector for the current client owner (all zero for the poller).
   always_comb begin
      resp_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner == PW'(i)) begin
            resp_onehot[i] = 1'b1;
         end else begin
            resp_onehot[i] = 1'b0;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next state: grant from IDLE, wait for done in ISSUE, single RESP cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (grant_found) begin
               next_state = ISSUE;
            end else begin
               next_state = IDLE;
            end
         end
         ISSUE: begin
            if (done_rise) begin
               next_state = RESP;
            end else begin
               next_state = ISSUE;
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Registered master interface, ownership, responses and link state.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rr_ptr      <= '0;
         owner       <= '0;
         mdio_start  <= 1'b0;
         mdio_mode   <= 1'b0;
         mdio_conf   <= 12'h000;
         mdio_wdata  <= 16'h0000;
         busy        <= 1'b0;
         resp_valid  <= '0;
         resp_rdata  <= 16'h0000;
         link_up     <= 1'b0;
         link_change <= 1'b0;
      end else begin
         resp_valid  <= '0;
         resp_rdata  <= 16'h0000;
         link_change <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_found) begin
                  owner      <= grant_idx;
                  mdio_start <= 1'b1;
                  mdio_mode  <= sel_mode;
                  mdio_conf  <= sel_conf;
                  mdio_wdata <= sel_wdata;
                  busy       <= 1'b1;
                  rr_ptr     <= (grant_idx == POLL_SLOT) ? '0 : grant_idx + PW'(1);
               end
            end
            ISSUE: begin
               if (done_rise) begin
                  mdio_start <= 1'b0;
                  if (owner_is_poll) begin
                     link_up     <= mdio_rdata[2];
                     link_change <= mdio_rdata[2] ^ link_up;
                  end else begin
                     resp_valid <= resp_onehot;
                     resp_rdata <= mdio_rdata;
                  end
               end
            end
            RESP: begin
               busy <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

   // Poll timer: one pending poll at most; disabling clears timer and pending request.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         poll_cnt     <= '0;
         poll_pending <= 1'b0;
      end else if (!poll_en) begin
         poll_cnt     <= '0;
         poll_pending <= 1'b0;
      end else begin
         if (poll_cnt == CNT_LAST) begin
            poll_cnt <= '0;
         end else begin
            poll_cnt <= poll_cnt + CW'(1);
         end
         if ((state == RESP) && owner_is_poll) begin
            poll_pending <= 1'b0;
         end else if (poll_cnt == CNT_LAST) begin
            poll_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mdio_ctrl.sv
// Directed bench for mdio_ctrl with a behavioural mdio master and a response
// scoreboard (expected responses queued at stimulus, popped on resp_valid).
module tb_mdio_ctrl;

   localparam int NR = 2;
   localparam int PP = 50;

   logic              clk = 1'b0;
   logic              arst_n = 1'b0;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_mode;
   logic [12*NR-1:0]  req_conf;
   logic [16*NR-1:0]  req_wdata;
   logic [NR-1:0]     resp_valid;
   logic [15:0]       resp_rdata;
   logic              busy;
   logic              poll_en;
   logic [4:0]        poll_phy;
   logic              link_up;
   logic              link_change;
   logic              mdio_start;
   logic              mdio_mode;
   logic [11:0]       mdio_conf;
   logic [15:0]       mdio_wdata;
   logic              mdio_done;
   logic [15:0]       mdio_rdata;

   typedef struct {
      logic [NR-1:0] vld;
      logic [15:0]   data;
      bit            chk;
   } exp_t;

   exp_t        sb[$];
   logic [11:0] start_log[$];
   int          total = 0;
   int          bad = 0;
   int          m_lat = 10;
   int          overlap = 0;
   logic [15:0] bmsr = 16'h0000;

   logic        m_active;
   logic        m_start_q;
   int          m_cnt;
   logic [11:0] m_conf;

   always #5 clk = ~clk;

   mdio_ctrl #(.NUM_REQ(NR), .POLL_PERIOD(PP)) dut (
      .clk(clk), .arst_n(arst_n),
      .req_valid(req_valid), .req_mode(req_mode), .req_conf(req_conf), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
      .poll_en(poll_en), .poll_phy(poll_phy), .link_up(link_up), .link_change(link_change),
      .mdio_start(mdio_start), .mdio_mode(mdio_mode), .mdio_conf(mdio_conf), .mdio_wdata(mdio_wdata),
      .mdio_done(mdio_done), .mdio_rdata(mdio_rdata)
   );

   function automatic logic [15:0] rd_val(logic [11:0] c);
      if (c == 12'h881)      return 16'h1234;
      else if (c == 12'h861) return bmsr;
      else                   return {4'h5, c};
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural mdio master: done rises m_lat cycles after start, falls once start drops.
   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         m_active   <= 1'b0;
         m_start_q  <= 1'b0;
         m_cnt      <= 0;
         m_conf     <= 12'h000;
         mdio_done  <= 1'b0;
         mdio_rdata <= 16'h0000;
      end else begin
         m_start_q <= mdio_start;
         if (mdio_start && !m_start_q) begin
            if (m_active) overlap <= overlap + 1;
            m_active <= 1'b1;
            m_cnt    <= m_lat;
            m_conf   <= mdio_conf;
            start_log.push_back(mdio_conf);
         end else if (m_active && !mdio_done) begin
            if (m_cnt == 0) begin
               mdio_done  <= 1'b1;
               mdio_rdata <= rd_val(m_conf);
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end else if (mdio_done && !mdio_start) begin
            mdio_done <= 1'b0;
            m_active  <= 1'b0;
         end
      end
   end

   // Scoreboard: every response pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (arst_n && (|resp_valid)) begin
         if (sb.size() == 0) begin
            check("resp_unexpected", 32'(resp_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check("resp_owner", 32'(resp_valid), 32'(e.vld));
            if (e.chk) check("resp_rdata", 32'(resp_rdata), 32'(e.data));
         end
      end
   end

   task automatic wait_resp(int i);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!resp_valid[i] && n < 600);
      check("resp_seen", 32'(resp_valid[i]), 32'd1);
   endtask

   task automatic wait_start();
      int n = 0;
      while (!mdio_start && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("start_seen", 32'(mdio_start), 32'd1);
   endtask

   task automatic wait_link_change();
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!link_change && n < 400);
      check("link_change_seen", 32'(link_change), 32'd1);
   endtask

   task automatic do_cmd(int i, logic [11:0] conf, logic [15:0] wd, bit chk, logic [15:0] exp_d);
      exp_t e;
      req_mode[i]           = 1'b0;
      req_conf[12*i +: 12]  = conf;
      req_wdata[16*i +: 16] = wd;
      e.vld = '0;
      e.vld[i] = 1'b1;
      e.data = exp_d;
      e.chk = chk;
      sb.push_back(e);
      req_valid[i] = 1'b1;
      wait_resp(i);
      req_valid[i] = 1'b0;
   endtask

   initial begin
      exp_t e;
      int   got;
      logic [11:0] lg;
      req_valid = '0;
      req_mode  = '0;
      req_conf  = '0;
      req_wdata = '0;
      poll_en   = 1'b0;
      poll_phy  = 5'd3;
      repeat (3) @(posedge clk);
      #1;
      check("rst_start", 32'(mdio_start), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_resp", 32'(resp_valid), 32'd0);
      check("rst_link", 32'({link_up, link_change}), 32'd0);
      arst_n = 1'b1;
      @(posedge clk); #1;

      // single client write, inputs scrambled mid-command
      req_conf[11:0]  = 12'h445;
      req_wdata[15:0] = 16'hBEEF;
      e.vld = 2'b01; e.data = 16'h0000; e.chk = 1'b0;
      sb.push_back(e);
      req_valid[0] = 1'b1;
      wait_start();
      check("wr_conf", 32'(mdio_conf), 32'h445);
      check("wr_wdata", 32'(mdio_wdata), 32'hBEEF);
      req_conf[11:0]  = 12'h000;
      req_wdata[15:0] = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      check("wr_conf_held", 32'(mdio_conf), 32'h445);
      check("wr_wdata_held", 32'(mdio_wdata), 32'hBEEF);
      check("wr_busy", 32'(busy), 32'd1);
      wait_resp(0);
      req_valid[0] = 1'b0;
      check("wr_start_low", 32'(mdio_start), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      check("wr_idle_busy", 32'(busy), 32'd0);
      check("wr_sb_empty", 32'(sb.size()), 32'd0);

      // client1 read
      do_cmd(1, 12'h881, 16'h0000, 1'b1, 16'h1234);
      repeat (3) @(posedge clk);
      #1;

      // round-robin with both clients held
      start_log.delete();
      req_conf  = {12'h4A2, 12'h4A1};
      req_wdata = {16'h2222, 16'h1111};
      for (int k = 0; k < 4; k++) begin
         e.vld = (k % 2 == 0) ? 2'b01 : 2'b10;
         e.chk = 1'b0;
         sb.push_back(e);
      end
      req_valid = 2'b11;
      got = 0;
      for (int n = 0; n < 2000 && got < 4; n++) begin
         @(posedge clk); #1;
         if (|resp_valid) got++;
      end
      req_valid = 2'b00;
      check("rr_count", 32'(got), 32'd4);
      repeat (20) @(posedge clk);
      #1;
      check("rr_starts", 32'(start_log.size()), 32'd4);
      for (int k = 0; k < 4 && k < start_log.size(); k++) begin
         lg = start_log[k];
         check("rr_order", 32'(lg), (k % 2 == 0) ? 32'h4A1 : 32'h4A2);
      end
      check("rr_overlap", 32'(overlap), 32'd0);

      // link poller
      start_log.delete();
      bmsr     = 16'h0004;
      poll_phy = 5'd3;
      poll_en  = 1'b1;
      wait_link_change();
      check("poll_link_up", 32'(link_up), 32'd1);
      lg = (start_log.size() > 0) ? start_log[0] : 12'hFFF;
      check("poll_conf", 32'(lg), 32'h861);
      bmsr = 16'h0000;
      @(posedge clk); #1;
      check("poll_pulse_1cyc", 32'(link_change), 32'd0);
      wait_link_change();
      check("poll_link_down", 32'(link_up), 32'd0);
      poll_en = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // poll expires during a long client0 command
      start_log.delete();
      m_lat = 200;
      bmsr  = 16'h0004;
      req_conf[11:0]  = 12'h4C0;
      req_wdata[15:0] = 16'h3333;
      e.vld = 2'b01; e.chk = 1'b0;
      sb.push_back(e);
      sb.push_back(e);
      req_valid[0] = 1'b1;
      poll_en      = 1'b1;
      wait_resp(0);
      m_lat = 10;
      wait_resp(0);
      req_valid[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("pc_starts", 32'(start_log.size()), 32'd3);
      lg = (start_log.size() > 1) ? start_log[1] : 12'hFFF;
      check("pc_poll_second", 32'(lg), 32'h861);
      lg = (start_log.size() > 2) ? start_log[2] : 12'hFFF;
      check("pc_client_third", 32'(lg), 32'h4C0);
      check("pc_link_up", 32'(link_up), 32'd1);
      poll_en = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // reset in the middle of ISSUE
      req_conf[11:0] = 12'h4D0;
      e.vld = 2'b01; e.chk = 1'b0;
      sb.push_back(e);
      req_valid[0] = 1'b1;
      wait_start();
      repeat (2) @(posedge clk);
      #2;
      arst_n = 1'b0;
      #1;
      check("mr_start", 32'(mdio_start), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_conf", 32'(mdio_conf), 32'd0);
      check("mr_link", 32'(link_up), 32'd0);
      sb.delete();
      req_valid = 2'b00;
      #10;
      arst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("mr_no_resp", 32'(resp_valid), 32'd0);
      do_cmd(1, 12'h881, 16'h0000, 1'b1, 16'h1234);
      repeat (3) @(posedge clk);
      #1;
      check("end_sb_empty", 32'(sb.size()), 32'd0);
      check("end_overlap", 32'(overlap), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
